order_emit: RTL and testbench

ORDER_EMIT -- requirements
Module: order_emit

---
 rtl/order_emit.sv | 191 +++++++++++++++++++
 tb/tb_order_emit.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/order_emit.sv
// order_emit: snapshots six symbol ranks and counts, inverts the rank map,
// checks that it is a permutation of 0..5, then streams the symbols in
// ascending rank order over a valid/ready handshake.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for start_emit_flg; order_err holds the last verdict
// BUILD  | one snapshot rank per cycle folded into inv[] and seen mask
// CHECK  | permutation verdict: go to EMIT or ERR
// EMIT   | item for current rank presented, advances on valid&&ready
// DONE   | emit_cmp_flg pulse, then back to IDLE
// ERR    | order_err raised, no items emitted, then back to IDLE
module order_emit (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_emit_flg,
    input  logic [2:0] order1,
    input  logic [2:0] order2,
    input  logic [2:0] order3,
    input  logic [2:0] order4,
    input  logic [2:0] order5,
    input  logic [2:0] order6,
    input  logic [7:0] CNT1,
    input  logic [7:0] CNT2,
    input  logic [7:0] CNT3,
    input  logic [7:0] CNT4,
    input  logic [7:0] CNT5,
    input  logic [7:0] CNT6,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [2:0] out_sym,
    output logic [7:0] out_cnt,
    output logic       out_last,
    output logic       busy,
    output logic       emit_cmp_flg,
    output logic       order_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BUILD,
        S_CHECK,
        S_EMIT,
        S_DONE,
        S_ERR
    } state_t;

    state_t     state_q;
    logic [2:0] rank_snap_q [6];
    logic [7:0] cnt_snap_q  [6];
    logic [2:0] inv_q       [6];
    logic [5:0] seen_q;
    logic       bad_q;
    logic [2:0] ptr_q;
    logic [2:0] rank_q;
    logic       out_valid_q;
    logic [2:0] out_sym_q;
    logic [7:0] out_cnt_q;
    logic       out_last_q;
    logic       emit_cmp_q;
    logic       order_err_q;

    logic [2:0] ord_in [6];
    logic [7:0] cnt_in [6];
    logic [2:0] cur_rank_d;
    logic       cur_bad_d;
    logic [2:0] rank_d;

    assign ord_in[0] = order1;
    assign ord_in[1] = order2;
    assign ord_in[2] = order3;
    assign ord_in[3] = order4;
    assign ord_in[4] = order5;
    assign ord_in[5] = order6;
    assign cnt_in[0] = CNT1;
    assign cnt_in[1] = CNT2;
    assign cnt_in[2] = CNT3;
    assign cnt_in[3] = CNT4;
    assign cnt_in[4] = CNT5;
    assign cnt_in[5] = CNT6;

    // Rank under inspection in BUILD; out-of-range ranks never touch seen/inv.
    always_comb begin
        cur_rank_d = rank_snap_q[ptr_q];
        cur_bad_d  = (cur_rank_d > 3'd5) ? 1'b1 : seen_q[cur_rank_d];
        rank_d     = rank_q + 3'd1;
    end

    // Sequencer: snapshot, inverse-map build, verdict and handshake emission.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            seen_q      <= '0;
            bad_q       <= 1'b0;
            ptr_q       <= '0;
            rank_q      <= '0;
            out_valid_q <= 1'b0;
            out_sym_q   <= '0;
            out_cnt_q   <= '0;
            out_last_q  <= 1'b0;
            emit_cmp_q  <= 1'b0;
            order_err_q <= 1'b0;
            for (int i = 0; i < 6; i++) begin
                rank_snap_q[i] <= '0;
                cnt_snap_q[i]  <= '0;
                inv_q[i]       <= '0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    emit_cmp_q <= 1'b0;
                    if (start_emit_flg) begin
                        for (int i = 0; i < 6; i++) begin
                            rank_snap_q[i] <= ord_in[i];
                            cnt_snap_q[i]  <= cnt_in[i];
                        end
                        seen_q      <= '0;
                        bad_q       <= 1'b0;
                        order_err_q <= 1'b0;
                        ptr_q       <= '0;
                        state_q     <= S_BUILD;
                    end
                end
                S_BUILD: begin
                    if (cur_bad_d) begin
                        bad_q <= 1'b1;
                    end else begin
                        inv_q[cur_rank_d]  <= ptr_q;
                        seen_q[cur_rank_d] <= 1'b1;
                    end
                    if (ptr_q == 3'd5) begin
                        ptr_q   <= '0;
                        state_q <= S_CHECK;
                    end else begin
                        ptr_q <= ptr_q + 3'd1;
                    end
                end
                S_CHECK: begin
                    if (bad_q || (seen_q != 6'b111111)) begin
                        order_err_q <= 1'b1;
                        state_q     <= S_ERR;
                    end else begin
                        rank_q      <= '0;
                        out_valid_q <= 1'b1;
                        out_sym_q   <= inv_q[0] + 3'd1;
                        out_cnt_q   <= cnt_snap_q[inv_q[0]];
                        out_last_q  <= 1'b0;
                        state_q     <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (out_valid_q && out_ready) begin
                        if (rank_q == 3'd5) begin
                            rank_q      <= '0;
                            out_valid_q <= 1'b0;
                            out_sym_q   <= '0;
                            out_cnt_q   <= '0;
                            out_last_q  <= 1'b0;
                            emit_cmp_q  <= 1'b1;
                            state_q     <= S_DONE;
                        end else begin
                            rank_q     <= rank_d;
                            out_sym_q  <= inv_q[rank_d] + 3'd1;
                            out_cnt_q  <= cnt_snap_q[inv_q[rank_d]];
                            out_last_q <= (rank_d == 3'd5);
                        end
                    end
                end
                S_DONE: begin
                    emit_cmp_q <= 1'b0;
                    state_q    <= S_IDLE;
                end
                S_ERR: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign out_valid    = out_valid_q;
    assign out_sym      = out_sym_q;
    assign out_cnt      = out_cnt_q;
    assign out_last     = out_last_q;
    assign busy         = (state_q != S_IDLE);
    assign emit_cmp_flg = emit_cmp_q;
    assign order_err    = order_err_q;

endmodule

// File: tb/tb_order_emit.sv
// Bench for order_emit: table of rank/count vectors with expected symbol
// order, a scoreboard queue checked on every accepted item, and hand
// sequences for backpressure, reset mid-emission and input perturbation.
module tb_order_emit;

    logic       clk = 1'b0;
    logic       reset, start_emit_flg, out_ready;
    logic [2:0] order1, order2, order3, order4, order5, order6;
    logic [7:0] CNT1, CNT2, CNT3, CNT4, CNT5, CNT6;
    logic       out_valid, out_last, busy, emit_cmp_flg, order_err;
    logic [2:0] out_sym;
    logic [7:0] out_cnt;

    order_emit dut (
        .clk(clk), .reset(reset), .start_emit_flg(start_emit_flg),
        .order1(order1), .order2(order2), .order3(order3),
        .order4(order4), .order5(order5), .order6(order6),
        .CNT1(CNT1), .CNT2(CNT2), .CNT3(CNT3), .CNT4(CNT4), .CNT5(CNT5), .CNT6(CNT6),
        .out_ready(out_ready), .out_valid(out_valid), .out_sym(out_sym),
        .out_cnt(out_cnt), .out_last(out_last), .busy(busy),
        .emit_cmp_flg(emit_cmp_flg), .order_err(order_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0][2:0] ord;
        logic [5:0][7:0] cnt;
        logic [5:0][2:0] exp_sym;
        logic            exp_err;
        logic [1:0]      rdy_mode;
    } vec_t;

    typedef struct packed {
        logic [2:0] sym;
        logic [7:0] cnt;
        logic       last;
    } exp_t;

    vec_t vecs [6];
    exp_t sb_q [$];
    int   checks = 0;
    int   failures = 0;
    int   acc_cnt = 0;
    logic mon_en = 1'b0;
    logic reset_prev = 1'b0;
    logic last_acc = 1'b0;
    logic hold_pend = 1'b0;
    logic [12:0] held = '0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
        end
    endtask

    function automatic logic [5:0][2:0] p3(input int a0, a1, a2, a3, a4, a5);
        return {3'(a5), 3'(a4), 3'(a3), 3'(a2), 3'(a1), 3'(a0)};
    endfunction

    function automatic logic [5:0][7:0] p8(input int a0, a1, a2, a3, a4, a5);
        return {8'(a5), 8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
    endfunction

    // Scoreboard monitor: pops on accepted items, checks holds and the done pulse.
    always @(negedge clk) begin
        if (mon_en) begin
            exp_t e;
            if (!out_valid) chk("idle_zero", {out_sym, out_cnt, out_last}, 0);
            if (hold_pend && reset_prev)
                chk("stall_hold", {out_valid, out_sym, out_cnt, out_last}, held);
            chk("cmp_pulse", emit_cmp_flg, last_acc && reset_prev);
            last_acc  = 1'b0;
            hold_pend = 1'b0;
            if (out_valid && reset) begin
                if (out_ready) begin
                    chk("sb_nonempty", sb_q.size() != 0, 1);
                    if (sb_q.size() != 0) begin
                        e = sb_q.pop_front();
                        chk("item_sym", out_sym, e.sym);
                        chk("item_cnt", out_cnt, e.cnt);
                        chk("item_last", out_last, e.last);
                    end
                    acc_cnt++;
                    last_acc = out_last;
                end else begin
                    hold_pend = 1'b1;
                    held = {out_valid, out_sym, out_cnt, out_last};
                end
            end
            reset_prev = reset;
        end
    end

    task automatic apply_inputs(input vec_t v);
        order1 = v.ord[0]; order2 = v.ord[1]; order3 = v.ord[2];
        order4 = v.ord[3]; order5 = v.ord[4]; order6 = v.ord[5];
        CNT1 = v.cnt[0]; CNT2 = v.cnt[1]; CNT3 = v.cnt[2];
        CNT4 = v.cnt[3]; CNT5 = v.cnt[4]; CNT6 = v.cnt[5];
    endtask

    task automatic push_expected(input vec_t v);
        exp_t e;
        for (int k = 0; k < 6; k++) begin
            e.sym  = v.exp_sym[k];
            e.cnt  = v.cnt[int'(v.exp_sym[k]) - 1];
            e.last = (k == 5);
            sb_q.push_back(e);
        end
    endtask

    // Start, fixed-latency checks, then drain with the vector's ready pattern.
    // perturb: scramble inputs right after the start edge and pulse start mid-EMIT.
    task automatic run_vec(input vec_t v, input bit perturb);
        bit done = 0;
        bit pulsed = 0;
        int stalls = 0;
        apply_inputs(v);
        acc_cnt = 0;
        if (!v.exp_err) push_expected(v);
        out_ready = (v.rdy_mode == 2'd1) ? 1'b0 : 1'b1;
        @(posedge clk); #2 start_emit_flg = 1'b1;
        @(posedge clk); #2 start_emit_flg = 1'b0;
        if (perturb) begin
            order1 = 3'd0; order2 = 3'd0; order3 = 3'd0;
            order4 = 3'd0; order5 = 3'd0; order6 = 3'd0;
            CNT1 = 8'hAA; CNT2 = 8'hAA; CNT3 = 8'hAA;
            CNT4 = 8'hAA; CNT5 = 8'hAA; CNT6 = 8'hAA;
        end
        @(negedge clk);
        chk("start_busy", busy, 1);
        chk("start_err_clr", order_err, 0);
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("pre_valid", out_valid, 0);
        @(posedge clk);
        @(negedge clk);
        chk("first_valid", out_valid, !v.exp_err);
        if (v.exp_err) begin
            chk("err_flag", order_err, 1);
            chk("err_busy", busy, 1);
            @(posedge clk);
            @(negedge clk);
            chk("err_idle_busy", busy, 0);
            repeat (3) @(negedge clk);
            chk("err_held", order_err, 1);
        end else begin
            for (int c = 0; c < 300 && !done; c++) begin
                @(posedge clk); #2;
                start_emit_flg = 1'b0;
                if (perturb && acc_cnt == 3 && !pulsed) begin
                    start_emit_flg = 1'b1;
                    pulsed = 1;
                end
                case (v.rdy_mode)
                    2'd1: out_ready = ($urandom_range(0, 3) != 0);
                    2'd2: begin
                        if (acc_cnt == 2 && stalls < 3) begin
                            out_ready = 1'b0;
                            stalls++;
                        end else out_ready = 1'b1;
                    end
                    default: out_ready = 1'b1;
                endcase
                @(negedge clk);
                if (emit_cmp_flg) done = 1;
            end
            chk("done_seen", done, 1);
            @(posedge clk); #2 out_ready = 1'b1;
            @(negedge clk);
            chk("post_busy", busy, 0);
            chk("post_cmp", emit_cmp_flg, 0);
            chk("sb_drained", sb_q.size(), 0);
        end
    endtask

    initial begin
        vecs[0] = '{ord: p3(0,1,2,3,4,5), cnt: p8(10,20,30,40,50,60),
                    exp_sym: p3(1,2,3,4,5,6), exp_err: 1'b0, rdy_mode: 2'd0};
        vecs[1] = '{ord: p3(5,4,3,2,1,0), cnt: p8(6,5,4,3,2,1),
                    exp_sym: p3(6,5,4,3,2,1), exp_err: 1'b0, rdy_mode: 2'd0};
        vecs[2] = '{ord: p3(2,0,5,1,4,3), cnt: p8(7,7,7,7,7,7),
                    exp_sym: p3(2,4,1,6,5,3), exp_err: 1'b0, rdy_mode: 2'd1};
        vecs[3] = '{ord: p3(1,1,2,3,4,5), cnt: p8(1,2,3,4,5,6),
                    exp_sym: p3(0,0,0,0,0,0), exp_err: 1'b1, rdy_mode: 2'd0};
        vecs[4] = '{ord: p3(0,1,2,3,4,7), cnt: p8(1,2,3,4,5,6),
                    exp_sym: p3(0,0,0,0,0,0), exp_err: 1'b1, rdy_mode: 2'd0};
        vecs[5] = '{ord: p3(3,5,0,4,2,1), cnt: p8(200,0,255,17,99,1),
                    exp_sym: p3(3,6,5,1,4,2), exp_err: 1'b0, rdy_mode: 2'd2};

        reset = 1'b0; start_emit_flg = 1'b0; out_ready = 1'b1;
        apply_inputs(vecs[0]);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_state", {out_valid, out_sym, out_cnt, out_last, busy, emit_cmp_flg, order_err}, 0);
        @(posedge clk); #2 reset = 1'b1;
        mon_en = 1'b1;

        for (int i = 0; i < 6; i++) run_vec(vecs[i], 1'b0);

        // Reset after two accepted items, with start asserted in the same cycle.
        apply_inputs(vecs[0]);
        acc_cnt = 0;
        push_expected(vecs[0]);
        out_ready = 1'b1;
        @(posedge clk); #2 start_emit_flg = 1'b1;
        @(posedge clk); #2 start_emit_flg = 1'b0;
        for (int c = 0; c < 50 && acc_cnt < 2; c++) begin
            @(posedge clk); #2;
        end
        chk("rst_reached_two", acc_cnt, 2);
        reset = 1'b0; start_emit_flg = 1'b1;
        @(posedge clk); #2 reset = 1'b1; start_emit_flg = 1'b0;
        @(negedge clk);
        chk("rst_outputs", {out_valid, out_sym, out_cnt, out_last, emit_cmp_flg, order_err}, 0);
        chk("rst_busy", busy, 0);
        sb_q.delete();

        run_vec(vecs[0], 1'b0);
        run_vec(vecs[1], 1'b1);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
